// File: rtl/dm_cache_param_ctrl_if.sv
// CPU-side and memory-side handshake bundle for the parametrised direct-mapped cache controller.
// The slave modport is the controller; the master modport is whoever drives CPU requests and serves memory.
interface dm_cache_param_ctrl_if #(
  parameter int ADDR_W         = 20,
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 4
);
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;

  logic              cpu_valid;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [WORD_W-1:0] cpu_rdata;
  logic              flush_req;
  logic              flush_done;
  logic              busy;
  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_data;
  logic              mem_resp_ready;
  logic [LINE_W-1:0] mem_resp_data;

  modport slave (
    input  cpu_valid, cpu_rw, cpu_addr, cpu_wdata, flush_req, mem_resp_ready, mem_resp_data,
    output cpu_ready, cpu_rdata, flush_done, busy, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
  );

  modport master (
    output cpu_valid, cpu_rw, cpu_addr, cpu_wdata, flush_req, mem_resp_ready, mem_resp_data,
    input  cpu_ready, cpu_rdata, flush_done, busy, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
  );
endinterface

// File: rtl/dm_cache_param_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with whole-cache flush.
// Tag/data live in block RAM with registered read; valid/dirty are resettable flops.
module dm_cache_param_ctrl #(
  parameter int ADDR_W         = 20,
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_LINES      = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  dm_cache_param_ctrl_if.slave bus
);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;

  typedef enum logic [2:0] {
    IDLE, COMPARE, WRITE_BACK, ALLOCATE, FLUSH_RD, FLUSH_CHK, FLUSH_WB
  } state_t;

  state_t              state_reg;
  logic [TAG_W-1:0]    tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]   data_mem [NUM_LINES];
  logic [TAG_W-1:0]    tag_rd_reg;
  logic [LINE_W-1:0]   line_rd_reg;
  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] dirty_reg;
  logic [IDX_W-1:0]    flush_cnt_reg;
  logic                mem_req_valid_reg;
  logic                mem_req_rw_reg;
  logic [ADDR_W-1:0]   mem_req_addr_reg;
  logic [LINE_W-1:0]   mem_req_data_reg;
  logic                busy_reg;
  logic                flush_done_reg;

  logic [TAG_W-1:0]    cpu_tag;
  logic [IDX_W-1:0]    cpu_idx;
  logic [OFF_W-1:0]    cpu_off;
  logic [IDX_W-1:0]    rd_idx;
  logic                in_flush;
  logic                hit;
  logic                mem_done;
  logic                flush_line_done;
  logic                data_we;
  logic                tag_we;
  logic [LINE_W-1:0]   data_wline;
  logic [LINE_W-1:0]   merged_line;
  logic [WORD_W-1:0]   rd_words [WORDS_PER_LINE];

  assign cpu_tag  = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign cpu_idx  = bus.cpu_addr[OFF_W +: IDX_W];
  assign cpu_off  = bus.cpu_addr[OFF_W-1:0];
  assign in_flush = (state_reg == FLUSH_RD) || (state_reg == FLUSH_CHK) || (state_reg == FLUSH_WB);
  // Flush states walk the arrays with the counter; everything else follows the CPU index.
  assign rd_idx   = in_flush ? flush_cnt_reg : cpu_idx;
  assign hit      = valid_reg[cpu_idx] && (tag_rd_reg == cpu_tag);
  assign mem_done = mem_req_valid_reg && bus.mem_resp_ready;
  assign flush_line_done =
      ((state_reg == FLUSH_CHK) && !(valid_reg[flush_cnt_reg] && dirty_reg[flush_cnt_reg])) ||
      ((state_reg == FLUSH_WB) && mem_done);

  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
      assign rd_words[gi] = line_rd_reg[gi*WORD_W +: WORD_W];
      assign merged_line[gi*WORD_W +: WORD_W] =
          (cpu_off == OFF_W'(gi)) ? bus.cpu_wdata : line_rd_reg[gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_comb begin
    data_we    = 1'b0;
    tag_we     = 1'b0;
    data_wline = merged_line;
    if (rst && (state_reg == COMPARE) && hit && bus.cpu_rw) begin
      data_we = 1'b1;
    end
    if (rst && (state_reg == ALLOCATE) && mem_done) begin
      data_we    = 1'b1;
      tag_we     = 1'b1;
      data_wline = bus.mem_resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_mem[cpu_idx] <= data_wline;
    if (tag_we)  tag_mem[cpu_idx]  <= cpu_tag;
    tag_rd_reg  <= tag_mem[rd_idx];
    line_rd_reg <= data_mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg         <= IDLE;
      valid_reg         <= '0;
      dirty_reg         <= '0;
      flush_cnt_reg     <= '0;
      mem_req_valid_reg <= 1'b0;
      mem_req_rw_reg    <= 1'b0;
      mem_req_addr_reg  <= '0;
      busy_reg          <= 1'b0;
      flush_done_reg    <= 1'b0;
    end else begin
      flush_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.flush_req) begin
            flush_cnt_reg <= '0;
            state_reg     <= FLUSH_RD;
            busy_reg      <= 1'b1;
          end else if (bus.cpu_valid) begin
            state_reg <= COMPARE;
            busy_reg  <= 1'b1;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (bus.cpu_rw) dirty_reg[cpu_idx] <= 1'b1;
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            mem_req_valid_reg <= 1'b1;
            mem_req_data_reg  <= line_rd_reg;
            if (valid_reg[cpu_idx] && dirty_reg[cpu_idx]) begin
              mem_req_rw_reg   <= 1'b1;
              mem_req_addr_reg <= {tag_rd_reg, cpu_idx, {OFF_W{1'b0}}};
              state_reg        <= WRITE_BACK;
            end else begin
              mem_req_rw_reg   <= 1'b0;
              mem_req_addr_reg <= {cpu_tag, cpu_idx, {OFF_W{1'b0}}};
              state_reg        <= ALLOCATE;
            end
          end
        end
        WRITE_BACK: begin
          if (mem_done) begin
            mem_req_rw_reg   <= 1'b0;
            mem_req_addr_reg <= {cpu_tag, cpu_idx, {OFF_W{1'b0}}};
            state_reg        <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_done) begin
            mem_req_valid_reg  <= 1'b0;
            valid_reg[cpu_idx] <= 1'b1;
            dirty_reg[cpu_idx] <= 1'b0;
            state_reg          <= IDLE;
            busy_reg           <= 1'b0;
          end
        end
        FLUSH_RD: state_reg <= FLUSH_CHK;
        FLUSH_CHK: begin
          if (valid_reg[flush_cnt_reg] && dirty_reg[flush_cnt_reg]) begin
            mem_req_valid_reg <= 1'b1;
            mem_req_rw_reg    <= 1'b1;
            mem_req_addr_reg  <= {tag_rd_reg, flush_cnt_reg, {OFF_W{1'b0}}};
            mem_req_data_reg  <= line_rd_reg;
            state_reg         <= FLUSH_WB;
          end
        end
        FLUSH_WB: begin
          if (mem_done) mem_req_valid_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase

      // Shared tail for clean lines and completed flush write-backs.
      if (flush_line_done) begin
        valid_reg[flush_cnt_reg] <= 1'b0;
        dirty_reg[flush_cnt_reg] <= 1'b0;
        if (flush_cnt_reg == '1) begin
          state_reg      <= IDLE;
          busy_reg       <= 1'b0;
          flush_done_reg <= 1'b1;
        end else begin
          flush_cnt_reg <= flush_cnt_reg + IDX_W'(1);
          state_reg     <= FLUSH_RD;
        end
      end
    end
  end

  assign bus.cpu_ready     = (state_reg == COMPARE) && hit;
  assign bus.cpu_rdata     = rd_words[cpu_off];
  assign bus.flush_done    = flush_done_reg;
  assign bus.busy          = busy_reg;
  assign bus.mem_req_valid = mem_req_valid_reg;
  assign bus.mem_req_rw    = mem_req_rw_reg;
  assign bus.mem_req_addr  = mem_req_addr_reg;
  assign bus.mem_req_data  = mem_req_data_reg;
endmodule

// File: doc/dm_cache_param_ctrl.md
# dm_cache_param_ctrl

Parametrised direct-mapped, write-back, write-allocate cache controller sitting between a CPU word port and a line-granular memory port. It generalises the fixed 16-bit-word, 4-word-line, 1024-line controller to configurable address, word, line and depth sizes. It owns its tag/data storage and keeps valid/dirty bits in resettable flops. It adds a whole-cache flush (write back every dirty line, invalidate all) and a busy indication.

## Interface
- ADDR_W, 20: CPU word-address width.
- WORD_W, 16: CPU data word width.
- WORDS_PER_LINE, 4: words per line; power of 2, at least 2. OFF_W = log2 of this.
- NUM_LINES, 1024: number of lines; power of 2. IDX_W = log2 of this.
- Derived: TAG_W = ADDR_W-IDX_W-OFF_W; LINE_W = WORD_W*WORDS_PER_LINE. Word k of a line occupies bits [k*WORD_W +: WORD_W].

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- cpu_valid  in  1  CPU request; held with addr/rw/wdata stable until cpu_ready.
- cpu_rw  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address: tag [ADDR_W-1:IDX_W+OFF_W], index [IDX_W+OFF_W-1:OFF_W], offset [OFF_W-1:0].
- cpu_wdata  in  WORD_W  write data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  WORD_W  read data, valid while cpu_ready=1.
- flush_req  in  1  level; sampled only in IDLE.
- flush_done  out  1  one-cycle pulse at flush end.
- busy  out  1  high whenever state != IDLE.
- mem_req_valid  out  1  memory request.
- mem_req_rw  out  1  1 = line write-back, 0 = line fill.
- mem_req_addr  out  ADDR_W  line address; offset bits are zero.
- mem_req_data  out  LINE_W  write-back line.
- mem_resp_ready  in  1  request completes this cycle.
- mem_resp_data  in  LINE_W  fill line, valid with mem_resp_ready.

## Operation
- Storage: tag RAM and data RAM, NUM_LINES deep, synchronous read, 1-cycle latency, no reset. Valid/dirty are NUM_LINES flops each.
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE, FLUSH_RD, FLUSH_CHK, FLUSH_WB.
- IDLE: arrays are addressed with the cpu_addr index every cycle.
  - flush_req=1: load flush counter with 0 and go to FLUSH_RD. Flush takes priority over cpu_valid.
  - Otherwise cpu_valid=1: go to COMPARE.
- COMPARE, hit (valid and tag match):
  - cpu_ready=1 combinationally.
  - Read: cpu_rdata = selected word.
  - Write: merge cpu_wdata into the selected word, write the line, set dirty.
  - Go to IDLE.
- COMPARE, miss:
  - Register the victim tag and line.
  - Victim invalid or clean: go to ALLOCATE. Valid and dirty: go to WRITE_BACK.
- WRITE_BACK: mem_req_valid=1, rw=1, addr={victim_tag,index,0}, data=victim line. On mem_resp_ready go to ALLOCATE.
- ALLOCATE: mem_req_valid=1, rw=0, addr={cpu tag,index,0}. On mem_resp_ready:
  - Write mem_resp_data and the tag.
  - Set valid, clear dirty.
  - Go to IDLE, which re-reads the arrays. The still-pending request then hits in the following COMPARE; a write hit sets dirty there.
- Flush:
  - FLUSH_RD addresses the arrays with the counter. FLUSH_CHK then tests the line.
  - Line valid and dirty: go to FLUSH_WB (write-back as in WRITE_BACK, address {tag,counter,0}). On mem_resp_ready return to the check-done path.
  - Per index: clear valid and dirty. If counter==NUM_LINES-1, pulse flush_done and go to IDLE; else increment and go to FLUSH_RD.
- mem_req_* stay stable while mem_req_valid=1. mem_req_valid is 0 in every other state.

## Timing
- Reset (rst=0 at a clk edge):
  - state=IDLE; all valid/dirty=0; flush counter=0.
  - cpu_ready=0, flush_done=0, busy=0, mem_req_valid=0.
  - mem_req_rw=0, mem_req_addr=0. cpu_rdata and mem_req_data are don't-care.
  - Reset mid-transaction abandons the memory request: mem_req_valid is 0 in the cycle after reset.
- Hit latency: 2 cycles (IDLE accept, COMPARE with cpu_ready). The CPU may present the next request in the cycle after cpu_ready.
- Clean miss: COMPARE, ALLOCATE (1+N cycles for N memory wait cycles), IDLE, COMPARE. That is 4+N cycles to cpu_ready.
- Dirty miss: adds 1+M cycles of WRITE_BACK.
- Memory handshake: a transfer completes in the cycle mem_resp_ready=1 with mem_req_valid=1. mem_resp_ready outside a request is ignored.
- Flush: 2*NUM_LINES cycles plus write-back time. flush_done is asserted in the cycle state returns to IDLE. A cpu_valid held during a flush is serviced afterwards and misses.
- flush_req still high in the IDLE cycle after flush_done starts a new flush.

## Test plan
All scenarios use default parameters; a zero-wait memory returns mem_resp_ready in the first request cycle.
- After reset, read 0x01234 -> mem read addr 0x01234; respond 0x4444_3333_2222_1111 -> cpu_ready in cycle 5 with cpu_rdata=0x1111.
- Then read 0x01236 -> cpu_ready in cycle 2, cpu_rdata=0x3333, mem_req_valid never high.
- Write 0x01235 data 0xBEEF (hit, cycle 2), then read 0x01235 -> 0xBEEF.
- Read 0x02234 -> write-back addr 0x01234 data 0x4444_3333_BEEF_1111, then fill addr 0x02234, then cpu_ready.
- Dirty 0x02234 line plus flush_req -> exactly one write-back (addr 0x02234), flush_done after 2*1024+1 cycles, busy high throughout. A later read of 0x02234 misses.
- rst=0 during ALLOCATE with memory stalled -> next cycle mem_req_valid=0, busy=0. Re-read of the earlier hit address misses.
